// File: rtl/rscl_bus_arb_if.sv
// rtl/rscl_bus_arb_if.sv - request type and bundled fetch/data/memory handshakes for the bus arbiter
package rscl_bus_arb_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } bus_req_t;
endpackage

interface rscl_bus_arb_if;
  import rscl_bus_arb_pkg::*;

  logic        i_a_valid, i_a_ready;
  logic [31:0] i_a_addr;
  logic        i_d_valid, i_d_ready, i_d_err;
  logic [31:0] i_d_data;
  logic        d_a_valid, d_a_ready;
  bus_req_t    d_a_req;
  logic        d_d_valid, d_d_ready, d_d_err;
  logic [31:0] d_d_data;
  logic        m_a_valid, m_a_ready;
  bus_req_t    m_a_req;
  logic        m_d_valid, m_d_ready, m_d_err;
  logic [31:0] m_d_data;

  modport slave (
    input  i_a_valid, i_a_addr, i_d_ready,
    input  d_a_valid, d_a_req, d_d_ready,
    input  m_a_ready, m_d_valid, m_d_err, m_d_data,
    output i_a_ready, i_d_valid, i_d_err, i_d_data,
    output d_a_ready, d_d_valid, d_d_err, d_d_data,
    output m_a_valid, m_a_req, m_d_ready
  );

  modport master (
    output i_a_valid, i_a_addr, i_d_ready,
    output d_a_valid, d_a_req, d_d_ready,
    output m_a_ready, m_d_valid, m_d_err, m_d_data,
    input  i_a_ready, i_d_valid, i_d_err, i_d_data,
    input  d_a_ready, d_d_valid, d_d_err, d_d_data,
    input  m_a_valid, m_a_req, m_d_ready
  );
endinterface

// File: rtl/rscl_bus_arb.sv
// rtl/rscl_bus_arb.sv - round-robin fetch/data arbiter onto one memory bus with in-order response routing
module rscl_bus_arb
  import rscl_bus_arb_pkg::*;
#(
  parameter int OUTST = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  rscl_bus_arb_if.slave  bus,
  output logic           arb_err
);

  localparam int PW = (OUTST > 1) ? $clog2(OUTST) : 1;

  typedef enum logic [1:0] {IDLE, HOLD_I, HOLD_D} state_e;

  state_e           state_q, state_d;
  logic             rr_d_q, rr_d_d;   // 1: last accepted request came from D
  logic [OUTST-1:0] own_q;            // per-slot owner, 1: D
  logic [PW-1:0]    wr_q, rd_q;
  logic [PW:0]      cnt_q;
  logic             arb_err_q;
  logic             grant_i, grant_d, full, empty, head_d, push, pop;

  assign arb_err = arb_err_q;

  always_comb begin
    state_d = state_q;
    rr_d_d  = rr_d_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    full    = (cnt_q == (PW+1)'(OUTST));
    empty   = (cnt_q == '0);

    if (rst_n) begin
      unique case (state_q)
        IDLE: begin
          if (!full) begin
            if (bus.i_a_valid && bus.d_a_valid) begin
              grant_d = !rr_d_q;
              grant_i = rr_d_q;
            end else begin
              grant_i = bus.i_a_valid;
              grant_d = bus.d_a_valid;
            end
          end
        end
        HOLD_I:  grant_i = 1'b1;
        HOLD_D:  grant_d = 1'b1;
        default: ;
      endcase
    end

    bus.m_a_valid = grant_i | grant_d;
    bus.m_a_req   = '0;
    if (grant_i) bus.m_a_req.addr = bus.i_a_addr;
    if (grant_d) bus.m_a_req = bus.d_a_req;
    bus.i_a_ready = grant_i & bus.m_a_ready;
    bus.d_a_ready = grant_d & bus.m_a_ready;

    push = bus.m_a_valid & bus.m_a_ready;
    if (push) begin
      state_d = IDLE;
      rr_d_d  = grant_d;
    end else if (grant_i) begin
      state_d = HOLD_I;
    end else if (grant_d) begin
      state_d = HOLD_D;
    end

    // Responses return in request order, so the FIFO head names the owner.
    head_d        = own_q[rd_q];
    bus.i_d_data  = bus.m_d_data;
    bus.d_d_data  = bus.m_d_data;
    bus.i_d_err   = bus.m_d_err;
    bus.d_d_err   = bus.m_d_err;
    bus.i_d_valid = rst_n & !empty & !head_d & bus.m_d_valid;
    bus.d_d_valid = rst_n & !empty &  head_d & bus.m_d_valid;
    if (empty)       bus.m_d_ready = rst_n;
    else if (head_d) bus.m_d_ready = rst_n & bus.d_d_ready;
    else             bus.m_d_ready = rst_n & bus.i_d_ready;

    pop = bus.m_d_valid & bus.m_d_ready & !empty;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_d_q    <= 1'b0;
      own_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      arb_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_d_q  <= rr_d_d;
      if (push) begin
        own_q[wr_q] <= grant_d;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (bus.m_d_valid && empty) arb_err_q <= 1'b1;
    end
  end

endmodule
